regs_out_reader: RTL and testbench
==================================

REGS_OUT_READER -- requirements
Module: regs_out_reader

Interface
REQ-001 The module SHALL have parameter N_THREADS, default 16, meaning number of hardware threads sharing the register file.
REQ-002 The module SHALL have parameter N_THREADS_MSB, default `MSB(N_THREADS-1), meaning the thread-number MSB.
REQ-003 The module SHALL have ports:
- CLK  in  1  sole clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a readout.
- start_thread_num  in  N_THREADS_MSB+1  thread to read.
- start_reg_addr  in  `REG_ADDR_MSB+1  first register address.
- start_count  in  4  word count; 0 encodes 16.
- busy  out  1  high from accepted start until done.
- rd_thread_num  out  N_THREADS_MSB+1  register-file read thread.
- rd_addr  out  `REG_ADDR_MSB+1  register-file read address.
- rd_en0  out  1  register-file array-read enable.
- rd_en1  out  1  register-file output-register enable.
- reg_dout  in  32  register-file read data.
- dout  out  32  output word.
- out_valid  out  1  dout holds a word.
- out_rd_en  in  1  consumer takes the word when out_valid is high.
- out_last  out  1  current dout is the final word of the readout.
- done  out  1  one-cycle pulse after the final word is taken.

Function
REQ-004 The register file SHALL be treated as two-stage read: rd_en0 with the address in cycle t, rd_en1 in cycle t+1, reg_dout valid and captured in cycle t+2.
REQ-005 A start SHALL be accepted only in IDLE; a start while busy SHALL be ignored with no state change.
REQ-006 The FSM SHALL have states IDLE, READ, DRAIN: IDLE->READ on start; READ->DRAIN when the last read is issued; DRAIN->IDLE when the last word is taken by the consumer.
REQ-007 Reads SHALL be issued in ascending address order; rd_addr SHALL wrap modulo 16 within the same thread (e.g. start 14, count 4 -> 14, 15, 0, 1).
REQ-008 Output SHALL go through a 3-entry FIFO; a read SHALL be issued only when FIFO occupancy plus in-flight reads is below 3, so no word is ever dropped.
REQ-009 rd_en1 SHALL equal rd_en0 delayed by one cycle; rd_thread_num and rd_addr SHALL hold while rd_en0 is low.
REQ-010 With out_rd_en held high, throughput SHALL be one word per cycle, and first-word latency SHALL be 3 cycles after start.
REQ-011 A simultaneous FIFO push and pop SHALL leave occupancy unchanged; a pop when empty SHALL be ignored.
REQ-012 out_last SHALL be high exactly with the count-th word; done SHALL pulse in the cycle after that word's out_valid&out_rd_en handshake.
REQ-013 dout SHALL be stable while out_valid is high and out_rd_en is low.

Reset
REQ-014 On rst the FSM SHALL enter IDLE, the FIFO and in-flight counters SHALL clear, and busy, rd_en0, rd_en1, out_valid, out_last and done SHALL be 0; rd_addr, rd_thread_num and dout SHALL be 0.
REQ-015 An rst mid-readout SHALL abort it with no done pulse; in-flight register data arriving after reset SHALL be discarded.

Structure
REQ-016 REG_ADDR_MSB and the MSB macro SHALL come from the shared sha512.vh header; no local redefinition.
REQ-017 The 3-entry FIFO SHALL be a separate sub-module, regs_out_fifo, using distributed/flip-flop storage, not block RAM.

Verification
REQ-018 start thread 5, addr 0, count 16, out_rd_en=1 -> 16 words, reg[5][0..15] in order, one per cycle, out_last on word 16, done one cycle later.
REQ-019 start addr 14, count 4 -> rd_addr sequence 14, 15, 0, 1, and thread number unchanged.
REQ-020 count 8, out_rd_en=0 for 10 cycles after start -> at most 3 reads issued, out_valid held with word 0 stable; on release all 8 words arrive with none lost.
REQ-021 A second start during a busy readout -> ignored; only the first readout's words are output.
REQ-022 rst asserted after 2 words -> all outputs 0 next edge, no done; a new start after reset reads correctly from its own address.
REQ-023 Toggling out_rd_en 1010... with count 5 -> exactly 5 handshakes, correct data, and FIFO occupancy never exceeds 3 (assertion).

Source files
------------

// File: rtl/regs_out_reader_pkg.sv
// Shared constants, state encoding and small helpers for the register-file
// readout block and its output FIFO.
package regs_out_reader_pkg;

    localparam int REG_ADDR_MSB = 3;
    localparam int FIFO_DEPTH   = 3;
    localparam int WORD_W       = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Index of the highest set bit; 0 for an argument of 0.
    function automatic int msb(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if (value[i]) begin
                result = i;
            end
        end
        return result;
    endfunction

    function automatic logic [4:0] count_words(input logic [3:0] count);
        return (count == 4'd0) ? 5'd16 : {1'b0, count};
    endfunction

    function automatic logic [1:0] fifo_ptr_inc(input logic [1:0] ptr);
        return (ptr == 2'(FIFO_DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
    endfunction

endpackage

// File: rtl/regs_out_reader_fifo.sv
// Three-entry flip-flop FIFO holding register words until the consumer takes
// them; pop on empty is ignored, push and pop together keep the occupancy.
module regs_out_fifo
    import regs_out_reader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic [WORD_W-1:0] dout,
    output logic              valid,
    output logic [1:0]        count
);

    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [WORD_W-1:0] mem_d [FIFO_DEPTH];
    logic [1:0]        wr_ptr_q, wr_ptr_d;
    logic [1:0]        rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              do_push, do_pop;

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        do_pop   = pop && (count_q != 2'd0);
        do_push  = push && ((count_q != 2'(FIFO_DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = fifo_ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = fifo_ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is left unreset; the count gates dout, so stale words never escape.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign valid = (count_q != 2'd0);
    assign dout  = valid ? mem_q[rd_ptr_q] : '0;
    assign count = count_q;

endmodule

// File: rtl/regs_out_reader.sv
// Streams count consecutive registers of one thread out of a two-stage
// register file into a small FIFO, issuing reads only when space is assured.
module regs_out_reader
    import regs_out_reader_pkg::*;
#(
    parameter int N_THREADS     = 16,
    parameter int N_THREADS_MSB = msb(N_THREADS - 1)
) (
    input  logic                    CLK,
    input  logic                    rst,
    input  logic                    start,
    input  logic [N_THREADS_MSB:0]  start_thread_num,
    input  logic [REG_ADDR_MSB:0]   start_reg_addr,
    input  logic [3:0]              start_count,
    output logic                    busy,
    output logic [N_THREADS_MSB:0]  rd_thread_num,
    output logic [REG_ADDR_MSB:0]   rd_addr,
    output logic                    rd_en0,
    output logic                    rd_en1,
    input  logic [WORD_W-1:0]       reg_dout,
    output logic [WORD_W-1:0]       dout,
    output logic                    out_valid,
    input  logic                    out_rd_en,
    output logic                    out_last,
    output logic                    done
);

    state_e                  state_q, state_d;
    logic [N_THREADS_MSB:0]  thread_q, thread_d;
    logic [REG_ADDR_MSB:0]   addr_q, addr_d;
    logic [4:0]              issue_left_q, issue_left_d;
    logic [4:0]              pop_left_q, pop_left_d;
    logic                    stage1_q, stage2_q;
    logic                    done_q, done_d;
    logic [1:0]              fifo_count;
    logic [2:0]              committed;
    logic                    pop, last_pop, credit, issue;

    always_comb begin
        pop       = out_valid && out_rd_en;
        last_pop  = pop && (pop_left_q == 5'd1);
        // Words stored or still in the read pipe, net of the word leaving now.
        committed = 3'(fifo_count) + 3'(stage1_q) + 3'(stage2_q) - 3'(pop);
        credit    = (committed < 3'(FIFO_DEPTH));

        state_d       = state_q;
        thread_d      = thread_q;
        addr_d        = addr_q;
        issue_left_d  = issue_left_q;
        pop_left_d    = pop ? pop_left_q - 5'd1 : pop_left_q;
        done_d        = last_pop;
        issue         = 1'b0;
        rd_thread_num = thread_q;
        rd_addr       = addr_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    issue         = 1'b1;
                    rd_thread_num = start_thread_num;
                    rd_addr       = start_reg_addr;
                    thread_d      = start_thread_num;
                    addr_d        = start_reg_addr;
                    issue_left_d  = count_words(start_count) - 5'd1;
                    pop_left_d    = count_words(start_count);
                    state_d       = READ;
                end
            end
            READ: begin
                if (issue_left_q == 5'd0) begin
                    state_d = DRAIN;
                end else if (credit) begin
                    issue        = 1'b1;
                    rd_addr      = addr_q + 1'b1;
                    addr_d       = addr_q + 1'b1;
                    issue_left_d = issue_left_q - 5'd1;
                    if (issue_left_q == 5'd1) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = DRAIN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (last_pop) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            thread_q     <= '0;
            addr_q       <= '0;
            issue_left_q <= '0;
            pop_left_q   <= '0;
            stage1_q     <= 1'b0;
            stage2_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            thread_q     <= thread_d;
            addr_q       <= addr_d;
            issue_left_q <= issue_left_d;
            pop_left_q   <= pop_left_d;
            stage1_q     <= issue;
            stage2_q     <= stage1_q;
            done_q       <= done_d;
        end
    end

    regs_out_fifo u_fifo (
        .clk       (CLK),
        .rst       (rst),
        .push      (stage2_q),
        .push_data (reg_dout),
        .pop       (pop),
        .dout      (dout),
        .valid     (out_valid),
        .count     (fifo_count)
    );

    assign rd_en0   = issue;
    assign rd_en1   = stage1_q;
    assign busy     = (state_q != IDLE);
    assign out_last = out_valid && (pop_left_q == 5'd1);
    assign done     = done_q;

endmodule

// File: tb/tb_regs_out_reader.sv
// Self-checking bench: a two-stage register-file model feeds the reader and a
// word-level scoreboard predicts every output word from thread/address/count.
module tb_regs_out_reader;

    typedef struct {
        logic [31:0] data;
        logic        first;
        logic        last;
    } exp_t;

    typedef struct {
        logic [3:0] thr;
        logic [3:0] addr;
    } iss_t;

    typedef struct {
        logic [3:0] thr;
        logic [3:0] addr;
        logic [3:0] cnt;
        int         exp_words;
        logic [3:0] exp_last_addr;
    } vec_t;

    logic        CLK;
    logic        rst;
    logic        start;
    logic [3:0]  start_thread_num;
    logic [3:0]  start_reg_addr;
    logic [3:0]  start_count;
    logic        busy;
    logic [3:0]  rd_thread_num;
    logic [3:0]  rd_addr;
    logic        rd_en0;
    logic        rd_en1;
    logic [31:0] reg_dout;
    logic [31:0] dout;
    logic        out_valid;
    logic        out_rd_en;
    logic        out_last;
    logic        done;

    regs_out_reader #(.N_THREADS(16)) dut (
        .CLK              (CLK),
        .rst              (rst),
        .start            (start),
        .start_thread_num (start_thread_num),
        .start_reg_addr   (start_reg_addr),
        .start_count      (start_count),
        .busy             (busy),
        .rd_thread_num    (rd_thread_num),
        .rd_addr          (rd_addr),
        .rd_en0           (rd_en0),
        .rd_en1           (rd_en1),
        .reg_dout         (reg_dout),
        .dout             (dout),
        .out_valid        (out_valid),
        .out_rd_en        (out_rd_en),
        .out_last         (out_last),
        .done             (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register file: address in cycle t, output register in t+1, data in t+2.
    logic [31:0] regs [16][16];
    logic [31:0] rf_s1;

    always @(posedge CLK) begin
        if (rd_en0) rf_s1 <= regs[rd_thread_num][rd_addr];
        if (rd_en1) reg_dout <= rf_s1;
    end

    // Scoreboard state, sampled on the falling edge.
    exp_t exp_q[$];
    iss_t issue_log[$];
    exp_t mon_e;
    iss_t mon_i;
    logic model_idle;
    logic done_pending;
    logic prev_en0;
    logic [3:0] prev_addr;
    logic [3:0] prev_thr;
    int   cyc = 0;
    int   hs_cnt = 0;
    int   accept_cyc = -1;
    int   first_hs_cyc = -1;
    int   last_hs_cyc = -1;
    int   done_cyc = -1;
    int   occ;
    int   n_words;

    always @(negedge CLK) begin
        if (rst) begin
            prev_en0     = 1'b0;
            prev_addr    = '0;
            prev_thr     = '0;
            done_pending = 1'b0;
        end else begin
            cyc++;
            model_idle = (exp_q.size() == 0);
            check("done", 32'(done), 32'(done_pending));
            if (done) done_cyc = cyc;
            done_pending = 1'b0;
            check("rd_en1_delay", 32'(rd_en1), 32'(prev_en0));
            if (!rd_en0) begin
                check("rd_addr_hold", 32'(rd_addr), 32'(prev_addr));
                check("rd_thread_hold", 32'(rd_thread_num), 32'(prev_thr));
            end
            occ = int'(dut.u_fifo.count_q) + int'(dut.stage1_q) + int'(dut.stage2_q);
            check("fifo_occupancy_le3", 32'(occ <= 3), 32'd1);
            check("busy", 32'(busy), 32'(!model_idle));
            if (out_valid) begin
                if (model_idle) begin
                    check("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    check("dout", dout, exp_q[0].data);
                    check("out_last", 32'(out_last), 32'(exp_q[0].last));
                    if (out_rd_en) begin
                        hs_cnt++;
                        if (exp_q[0].first) first_hs_cyc = cyc;
                        if (exp_q[0].last) begin
                            last_hs_cyc  = cyc;
                            done_pending = 1'b1;
                        end
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                check("out_last_without_valid", 32'(out_last), 32'd0);
            end
            if (rd_en0) begin
                mon_i.thr  = rd_thread_num;
                mon_i.addr = rd_addr;
                issue_log.push_back(mon_i);
            end
            if (start && model_idle) begin
                accept_cyc = cyc;
                n_words = (start_count == 4'd0) ? 16 : int'(start_count);
                for (int i = 0; i < n_words; i++) begin
                    mon_e.data  = regs[start_thread_num][(int'(start_reg_addr) + i) % 16];
                    mon_e.first = (i == 0);
                    mon_e.last  = (i == n_words - 1);
                    exp_q.push_back(mon_e);
                end
            end
            prev_en0  = rd_en0;
            prev_addr = rd_addr;
            prev_thr  = rd_thread_num;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input logic [3:0] thr, input logic [3:0] addr, input logic [3:0] cnt);
        start            = 1'b1;
        start_thread_num = thr;
        start_reg_addr   = addr;
        start_count      = cnt;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            tests++;
            fails++;
            $display("FAIL wait_idle: readout still pending after %0d cycles, expected idle", budget);
        end
        repeat (2) tick();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_rd_en0"}, 32'(rd_en0), 32'd0);
        check({tag, "_rd_en1"}, 32'(rd_en1), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        check({tag, "_rd_thread_num"}, 32'(rd_thread_num), 32'd0);
        check({tag, "_dout"}, dout, 32'd0);
    endtask

    vec_t vecs[5];
    int   hs0;
    int   n;

    initial begin
        vecs[0] = '{thr: 4'd3,  addr: 4'd14, cnt: 4'd4,  exp_words: 4,  exp_last_addr: 4'd1};
        vecs[1] = '{thr: 4'd7,  addr: 4'd9,  cnt: 4'd1,  exp_words: 1,  exp_last_addr: 4'd9};
        vecs[2] = '{thr: 4'd0,  addr: 4'd15, cnt: 4'd0,  exp_words: 16, exp_last_addr: 4'd14};
        vecs[3] = '{thr: 4'd15, addr: 4'd3,  cnt: 4'd8,  exp_words: 8,  exp_last_addr: 4'd10};
        vecs[4] = '{thr: 4'd12, addr: 4'd10, cnt: 4'd15, exp_words: 15, exp_last_addr: 4'd8};

        for (int t = 0; t < 16; t++)
            for (int a = 0; a < 16; a++)
                regs[t][a] = $urandom;
        rf_s1            = '0;
        reg_dout         = '0;
        rst              = 1'b1;
        start            = 1'b0;
        start_thread_num = '0;
        start_reg_addr   = '0;
        start_count      = '0;
        out_rd_en        = 1'b0;

        repeat (3) tick();
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (2) tick();

        // Full 16-word readout: latency, throughput, out_last and done timing.
        out_rd_en = 1'b1;
        hs0 = hs_cnt;
        done_cyc = -1;
        do_start(4'd5, 4'd0, 4'd0);
        wait_idle(100);
        check("full_words", 32'(hs_cnt - hs0), 32'd16);
        check("first_word_latency", 32'(first_hs_cyc - accept_cyc), 32'd3);
        check("one_word_per_cycle", 32'(last_hs_cyc - first_hs_cyc), 32'd15);
        check("done_after_last", 32'(done_cyc - last_hs_cyc), 32'd1);

        // Table of readouts: word count, address wrap and fixed thread.
        for (int v = 0; v < 5; v++) begin
            issue_log.delete();
            hs0 = hs_cnt;
            out_rd_en = 1'b1;
            do_start(vecs[v].thr, vecs[v].addr, vecs[v].cnt);
            wait_idle(100);
            check($sformatf("vec%0d_words", v), 32'(hs_cnt - hs0), 32'(vecs[v].exp_words));
            check($sformatf("vec%0d_reads", v), 32'(issue_log.size()), 32'(vecs[v].exp_words));
            if (issue_log.size() > 0) begin
                check($sformatf("vec%0d_first_addr", v), 32'(issue_log[0].addr), 32'(vecs[v].addr));
                check($sformatf("vec%0d_last_addr", v), 32'(issue_log[$].addr), 32'(vecs[v].exp_last_addr));
            end
            foreach (issue_log[k])
                check($sformatf("vec%0d_thread", v), 32'(issue_log[k].thr), 32'(vecs[v].thr));
        end

        // Consumer stalled: no more than three reads may be outstanding.
        issue_log.delete();
        hs0 = hs_cnt;
        out_rd_en = 1'b0;
        do_start(4'd2, 4'd6, 4'd8);
        repeat (9) tick();
        check("stall_reads", 32'(issue_log.size()), 32'd3);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        out_rd_en = 1'b1;
        wait_idle(100);
        check("stall_words", 32'(hs_cnt - hs0), 32'd8);

        // A start while busy is ignored.
        hs0 = hs_cnt;
        do_start(4'd1, 4'd0, 4'd6);
        tick();
        do_start(4'd9, 4'd3, 4'd4);
        wait_idle(100);
        check("second_start_ignored", 32'(hs_cnt - hs0), 32'd6);

        // Reset after two words: outputs clear, no done, next readout clean.
        hs0 = hs_cnt;
        do_start(4'd4, 4'd2, 4'd0);
        n = 0;
        while (hs_cnt - hs0 < 2 && n < 50) begin
            tick();
            n++;
        end
        check("pre_reset_words", 32'(hs_cnt - hs0), 32'd2);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check_outputs_zero("abort");
        tick();
        tick();
        rst = 1'b0;
        repeat (4) tick();
        issue_log.delete();
        hs0 = hs_cnt;
        do_start(4'd11, 4'd13, 4'd3);
        wait_idle(100);
        check("post_reset_words", 32'(hs_cnt - hs0), 32'd3);
        if (issue_log.size() > 0)
            check("post_reset_addr", 32'(issue_log[0].addr), 32'd13);

        // Alternating consumer.
        hs0 = hs_cnt;
        do_start(4'd6, 4'd7, 4'd5);
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 60) begin
            out_rd_en = ~out_rd_en;
            tick();
            n++;
        end
        out_rd_en = 1'b1;
        wait_idle(20);
        check("toggle_handshakes", 32'(hs_cnt - hs0), 32'd5);

        // Random starts, parameters and back-pressure.
        for (int i = 0; i < 1500; i++) begin
            out_rd_en        = ($urandom_range(0, 3) != 0);
            start            = ($urandom_range(0, 9) == 0);
            start_thread_num = 4'($urandom_range(0, 15));
            start_reg_addr   = 4'($urandom_range(0, 15));
            start_count      = 4'($urandom_range(0, 15));
            tick();
        end
        start = 1'b0;
        out_rd_en = 1'b1;
        wait_idle(100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
